// File: rtl/alu_multicycle_if.sv
// Operand/result handshake bundle for alu_multicycle.
// The master side presents operations and accepts results; the slave is the ALU.
interface alu_multicycle_if #(
   parameter int WIDTH = 8
) ();
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic [2:0]           op;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   result;
   logic                 carry;
   logic                 zero;
   logic                 overflow;
   logic                 div_by_zero;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, carry, zero, overflow, div_by_zero
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, carry, zero, overflow, div_by_zero
   );
endinterface

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle ADD/SUB/logic ops, bit-serial shift-add MUL
// and restoring DIV taking WIDTH cycles. Every output comes from a flop.
module alu_multicycle #(
   parameter int WIDTH = 8
) (
   input  logic               clock,
   input  logic               reset,
   alu_multicycle_if.slave    bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_XOR = 3'b110;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 is_mul_q, is_mul_d;
   logic [WIDTH-1:0]     hi_q, hi_d;      // MUL: partial product high half; DIV: remainder
   logic [WIDTH-1:0]     lo_q, lo_d;      // MUL: multiplier/product low; DIV: dividend/quotient
   logic [WIDTH-1:0]     b_q, b_d;        // multiplicand or divisor
   logic [2*WIDTH-1:0]   result_q, result_d;
   logic                 carry_q, carry_d;
   logic                 zero_q, zero_d;
   logic                 overflow_q, overflow_d;
   logic                 dbz_q, dbz_d;
   logic                 in_ready_q, in_ready_d;
   logic                 out_valid_q, out_valid_d;

   // Single-cycle operation results, evaluated straight from the bus at accept time
   logic [WIDTH:0]       add_w, sub_w;
   logic [2*WIDTH-1:0]   short_res;
   logic                 short_carry, short_ovf, short_dbz;
   logic                 is_long;

   assign add_w   = {1'b0, bus.a} + {1'b0, bus.b};
   assign sub_w   = {1'b0, bus.a} - {1'b0, bus.b};
   assign is_long = (bus.op == OP_MUL) || ((bus.op == OP_DIV) && (bus.b != '0));

   // Short-path result and flags; reserved opcode falls through to all-zero
   always_comb begin
      short_res   = '0;
      short_carry = 1'b0;
      short_ovf   = 1'b0;
      short_dbz   = 1'b0;
      case (bus.op)
         OP_ADD: begin
            short_res   = {{WIDTH{1'b0}}, add_w[WIDTH-1:0]};
            short_carry = add_w[WIDTH];
            short_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                          (add_w[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_SUB: begin
            short_res   = {{WIDTH{1'b0}}, sub_w[WIDTH-1:0]};
            short_carry = sub_w[WIDTH];
            short_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                          (sub_w[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_DIV: begin
            // Only reached on the short path when the divisor is zero
            short_res = {bus.a, {WIDTH{1'b1}}};
            short_dbz = 1'b1;
         end
         OP_AND:  short_res = {{WIDTH{1'b0}}, bus.a & bus.b};
         OP_OR:   short_res = {{WIDTH{1'b0}}, bus.a | bus.b};
         OP_XOR:  short_res = {{WIDTH{1'b0}}, bus.a ^ bus.b};
         default: short_res = '0;
      endcase
   end

   // One bit-serial step of the multiplier and of the divider
   logic [WIDTH:0]       mul_sum, div_shift, div_trial;
   logic [WIDTH-1:0]     hi_step, lo_step;

   assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
   assign div_shift = {hi_q, lo_q[WIDTH-1]};
   assign div_trial = div_shift - {1'b0, b_q};

   // Select the step result for the active operation (restoring on negative trial)
   always_comb begin
      hi_step = hi_q;
      lo_step = lo_q;
      if (is_mul_q) begin
         hi_step = mul_sum[WIDTH:1];
         lo_step = {mul_sum[0], lo_q[WIDTH-1:1]};
      end else if (!div_trial[WIDTH]) begin
         hi_step = div_trial[WIDTH-1:0];
         lo_step = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
         hi_step = div_shift[WIDTH-1:0];
         lo_step = {lo_q[WIDTH-2:0], 1'b0};
      end
   end

   // Next-state and datapath control for IDLE -> (CALC) -> DONE
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      is_mul_d   = is_mul_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      b_d        = b_q;
      result_d   = result_q;
      carry_d    = carry_q;
      zero_d     = zero_q;
      overflow_d = overflow_q;
      dbz_d      = dbz_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               if (is_long) begin
                  is_mul_d = (bus.op == OP_MUL);
                  hi_d     = '0;
                  lo_d     = bus.a;
                  b_d      = bus.b;
                  cnt_d    = '0;
                  state_d  = CALC;
               end else begin
                  result_d   = short_res;
                  carry_d    = short_carry;
                  overflow_d = short_ovf;
                  dbz_d      = short_dbz;
                  zero_d     = (short_res == '0);
                  state_d    = DONE;
               end
            end
         end
         CALC: begin
            hi_d  = hi_step;
            lo_d  = lo_step;
            cnt_d = cnt_q + 1'b1;
            // Final step lands straight in the result registers
            if (cnt_q == LAST_STEP) begin
               result_d   = {hi_step, lo_step};
               carry_d    = 1'b0;
               overflow_d = is_mul_q && (hi_step != '0);
               dbz_d      = 1'b0;
               zero_d     = ({hi_step, lo_step} == '0);
               state_d    = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   // State and datapath registers; reset aborts any operation in flight
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         is_mul_q    <= 1'b0;
         hi_q        <= '0;
         lo_q        <= '0;
         b_q         <= '0;
         result_q    <= '0;
         carry_q     <= 1'b0;
         zero_q      <= 1'b0;
         overflow_q  <= 1'b0;
         dbz_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         is_mul_q    <= is_mul_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         b_q         <= b_d;
         result_q    <= result_d;
         carry_q     <= carry_d;
         zero_q      <= zero_d;
         overflow_q  <= overflow_d;
         dbz_q       <= dbz_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.result      = result_q;
   assign bus.carry       = carry_q;
   assign bus.zero        = zero_q;
   assign bus.overflow    = overflow_q;
   assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=8): directed table, corner
// sequences, and random operations against an arithmetic reference model.
module tb_alu_multicycle;
   localparam int W = 8;

   logic clk;
   logic rst;

   alu_multicycle_if #(.WIDTH(W)) bus ();

   alu_multicycle #(.WIDTH(W)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] result;
      logic        carry;
      logic        zero;
      logic        ovf;
      logic        dbz;
      int          lat;
   } exp_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] op;
      int         hold;
      exp_t       exp;
   } vec_t;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference model: plain integer arithmetic on the operation definitions
   function automatic exp_t ref_model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      exp_t e;
      int ia, ib, sa, sb, s, ss;
      ia = int'(a);
      ib = int'(b);
      sa = (ia > 127) ? ia - 256 : ia;
      sb = (ib > 127) ? ib - 256 : ib;
      e.result = 16'h0; e.carry = 1'b0; e.ovf = 1'b0; e.dbz = 1'b0;
      case (op)
         3'd0: begin
            s = ia + ib; ss = sa + sb;
            e.result = 16'(s % 256); e.carry = (s > 255); e.ovf = (ss > 127) || (ss < -128);
         end
         3'd1: begin
            s = ia - ib; ss = sa - sb;
            e.result = 16'((s + 256) % 256); e.carry = (ia < ib); e.ovf = (ss > 127) || (ss < -128);
         end
         3'd2: begin
            s = ia * ib;
            e.result = 16'(s); e.ovf = (s > 255);
         end
         3'd3: begin
            if (ib == 0) begin
               e.result = 16'(ia * 256 + 255); e.dbz = 1'b1;
            end else begin
               e.result = 16'((ia % ib) * 256 + (ia / ib));
            end
         end
         3'd4: e.result = 16'(ia & ib);
         3'd5: e.result = 16'(ia | ib);
         3'd6: e.result = 16'(ia ^ ib);
         default: e.result = 16'h0;
      endcase
      e.zero = (e.result == 16'h0);
      e.lat  = ((op == 3'd2) || ((op == 3'd3) && (ib != 0))) ? W + 1 : 1;
      return e;
   endfunction

   // One full transaction: present, wait for result, hold off, then release.
   // Called at posedge+1 with the DUT idle.
   task automatic run_op(input logic [7:0] ta, input logic [7:0] tbv, input logic [2:0] top,
                         input int hold, input exp_t e);
      int lat;
      int busy_err;
      int stab_err;
      logic [15:0] held;
      busy_err = 0;
      stab_err = 0;
      chk("ready_before", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.a  = ta;
      bus.b  = tbv;
      bus.op = top;
      @(posedge clk); #1;
      // Scramble inputs after accept; the DUT must have captured them
      bus.in_valid = 1'b0;
      bus.a  = 8'($urandom);
      bus.b  = 8'($urandom);
      bus.op = 3'($urandom);
      lat = 1;
      while (!bus.out_valid && lat < 40) begin
         if (bus.in_ready) busy_err++;
         @(posedge clk); #1;
         lat++;
      end
      chk("latency",   32'(lat), 32'(e.lat));
      chk("busy_ready", 32'(busy_err), 32'd0);
      chk("result",    32'(bus.result), 32'(e.result));
      chk("carry",     32'(bus.carry), 32'(e.carry));
      chk("zero",      32'(bus.zero), 32'(e.zero));
      chk("overflow",  32'(bus.overflow), 32'(e.ovf));
      chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
      chk("ready_done", 32'(bus.in_ready), 32'd0);
      held = bus.result;
      $display("op=%0d a=%02h b=%02h result=%04h c=%0b z=%0b o=%0b dz=%0b lat=%0d hold=%0d",
               top, ta, tbv, bus.result, bus.carry, bus.zero, bus.overflow, bus.div_by_zero, lat, hold);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         if (bus.result !== held || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) stab_err++;
      end
      if (hold > 0) chk("hold_stable", 32'(stab_err), 32'd0);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("released_valid", 32'(bus.out_valid), 32'd0);
      chk("released_ready", 32'(bus.in_ready), 32'd1);
   endtask

   function automatic exp_t mk(input logic [15:0] r, input logic c, input logic z,
                               input logic o, input logic d, input int lat);
      exp_t e;
      e.result = r; e.carry = c; e.zero = z; e.ovf = o; e.dbz = d; e.lat = lat;
      return e;
   endfunction

   vec_t vecs[14];

   initial begin
      int no_valid_err;
      exp_t e;
      logic [7:0] ra, rb;
      logic [2:0] rop;

      // Directed vectors with hand-derived expectations
      vecs[0]  = '{8'hFF, 8'h01, 3'd0, 0, mk(16'h0000, 1, 1, 0, 0, 1)};
      vecs[1]  = '{8'h80, 8'h01, 3'd1, 0, mk(16'h007F, 0, 0, 1, 0, 1)};
      vecs[2]  = '{8'h01, 8'h02, 3'd1, 0, mk(16'h00FF, 1, 0, 0, 0, 1)};
      vecs[3]  = '{8'hFF, 8'hFF, 3'd2, 0, mk(16'hFE01, 0, 0, 1, 0, 9)};
      vecs[4]  = '{8'd100, 8'd7, 3'd3, 0, mk(16'h020E, 0, 0, 0, 0, 9)};
      vecs[5]  = '{8'h64, 8'h00, 3'd3, 0, mk(16'h64FF, 0, 0, 0, 1, 1)};
      vecs[6]  = '{8'hF0, 8'hFF, 3'd6, 5, mk(16'h000F, 0, 0, 0, 0, 1)};
      vecs[7]  = '{8'hF0, 8'h3C, 3'd4, 0, mk(16'h0030, 0, 0, 0, 0, 1)};
      vecs[8]  = '{8'h0F, 8'hF0, 3'd5, 0, mk(16'h00FF, 0, 0, 0, 0, 1)};
      vecs[9]  = '{8'h12, 8'h34, 3'd7, 0, mk(16'h0000, 0, 1, 0, 0, 1)};
      vecs[10] = '{8'h7F, 8'h01, 3'd0, 0, mk(16'h0080, 0, 0, 1, 0, 1)};
      vecs[11] = '{8'h00, 8'h05, 3'd2, 2, mk(16'h0000, 0, 1, 0, 0, 9)};
      vecs[12] = '{8'h10, 8'h10, 3'd2, 0, mk(16'h0100, 0, 0, 1, 0, 9)};
      vecs[13] = '{8'h05, 8'h09, 3'd3, 3, mk(16'h0500, 0, 0, 0, 0, 9)};

      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a  = '0;
      bus.b  = '0;
      bus.op = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
      chk("rst_result",    32'(bus.result), 32'd0);
      chk("rst_flags",     32'({bus.carry, bus.zero, bus.overflow, bus.div_by_zero}), 32'd0);
      rst = 1'b0;

      // Directed table; first entry is accepted on the first edge after release
      for (int i = 0; i < 14; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].hold, vecs[i].exp);
      end

      // Reset in the middle of a multiply aborts it
      bus.in_valid = 1'b1;
      bus.a  = 8'hFF;
      bus.b  = 8'hFF;
      bus.op = 3'd2;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
      chk("abort_result",    32'(bus.result), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
      no_valid_err = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid) no_valid_err++;
      end
      chk("abort_no_result", 32'(no_valid_err), 32'd0);
      run_op(8'h03, 8'h04, 3'd0, 0, mk(16'h0007, 0, 0, 0, 0, 1));

      // Random operations against the reference model
      for (int n = 0; n < 150; n++) begin
         ra  = 8'($urandom);
         rb  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         rop = 3'($urandom);
         e   = ref_model(ra, rb, rop);
         run_op(ra, rb, rop, $urandom_range(0, 2), e);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
